// File: rtl/team_02_wbm_pkg.sv
// Shared types and constants for the team_02 Wishbone master arbiter.
// Bus widths, FSM state encoding and the error-response data value.
package team_02_wbm_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/team_02_rr_picker.sv
// Combinational round-robin picker: searches req_i starting at ptr_i,
// wrapping around, and returns the first set requester as one-hot.
module team_02_rr_picker #(
    parameter int NREQ = 2,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;

    // Walk NREQ slots from the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/team_02_wbm_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone master port among
// NREQ requesters, one single-beat cycle at a time, with bus timeout.
module team_02_wbm_arbiter
    import team_02_wbm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        req_we_i,
    input  logic [NREQ*32-1:0]     req_adr_i,
    input  logic [NREQ*32-1:0]     req_dat_i,
    input  logic [NREQ*4-1:0]      req_sel_i,
    output logic [NREQ-1:0]        req_ack_o,
    output logic                   req_err_o,
    output logic [WB_DAT_W-1:0]    req_rdata_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic [WB_ADR_W-1:0]    ADR_O,
    output logic [WB_DAT_W-1:0]    DAT_O,
    output logic [WB_SEL_W-1:0]    SEL_O,
    output logic                   WE_O,
    output logic                   STB_O,
    output logic                   CYC_O,
    input  logic                   ACK_I,
    input  logic [WB_DAT_W-1:0]    DAT_I
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         gidx_q, gidx_d;
    logic [NREQ-1:0]       grant_q, grant_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         cnt_inc;
    logic [WB_ADR_W-1:0]   adr_q, adr_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic                  err_q, err_d;
    logic [WB_DAT_W-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0]       win;
    logic                  win_vld;
    logic [PW-1:0]         win_idx;
    logic                  win_we;
    logic [WB_ADR_W-1:0]   win_adr;
    logic [WB_DAT_W-1:0]   win_dat;
    logic [WB_SEL_W-1:0]   win_sel;

    team_02_rr_picker #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (win),
        .valid_o (win_vld)
    );

    // Mux the winning requester's fields onto the latch inputs.
    always_comb begin
        win_idx = '0;
        win_we  = 1'b0;
        win_adr = '0;
        win_dat = '0;
        win_sel = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (win[n]) begin
                win_idx = PW'(n);
                win_we  = req_we_i[n];
                win_adr = req_adr_i[32*n +: 32];
                win_dat = req_dat_i[32*n +: 32];
                win_sel = req_sel_i[4*n +: 4];
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state logic: IDLE arbitrates, BUS waits for ACK or timeout,
    // RESP pulses the ack and advances the priority pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d = ST_BUS;
                    grant_d = win;
                    gidx_d  = win_idx;
                    adr_d   = win_adr;
                    dat_d   = win_dat;
                    sel_d   = win_sel;
                    we_d    = win_we;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_BUS: begin
                if (ACK_I) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    rdata_d = DAT_I;
                    ack_d   = grant_q;
                end else if (cnt_inc == TO_V) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    rdata_d = ERR_RDATA;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = (gidx_q == LAST) ? '0 : gidx_q + PW'(1);
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ack_o   = ack_q;
    assign req_err_o   = err_q;
    assign req_rdata_o = rdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign ADR_O       = adr_q;
    assign DAT_O       = dat_q;
    assign SEL_O       = sel_q;
    assign WE_O        = we_q;
    assign STB_O       = cyc_q;
    assign CYC_O       = cyc_q;

endmodule

// File: tb/tb_team_02_wbm_arbiter.sv
// Directed bench for team_02_wbm_arbiter (NREQ=2, TIMEOUT=4).
// Per-cycle vector table plus hand-written multi-cycle sequences.
module tb_team_02_wbm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [63:0] req_adr;
    logic [63:0] req_dat;
    logic [7:0]  req_sel;
    logic [1:0]  rack;
    logic        rerr;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    logic        busy;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;
    logic [31:0] dat_i;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A0 = 32'h3000_0010;
    localparam logic [31:0] A1 = 32'h4000_0020;

    always #5 clk = ~clk;

    team_02_wbm_arbiter #(
        .NREQ    (2),
        .TIMEOUT (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_adr_i   (req_adr),
        .req_dat_i   (req_dat),
        .req_sel_i   (req_sel),
        .req_ack_o   (rack),
        .req_err_o   (rerr),
        .req_rdata_o (rdata),
        .grant_o     (gnt),
        .busy_o      (busy),
        .ADR_O       (adr_o),
        .DAT_O       (dat_o),
        .SEL_O       (sel_o),
        .WE_O        (we_o),
        .STB_O       (stb_o),
        .CYC_O       (cyc_o),
        .ACK_I       (ack_i),
        .DAT_I       (dat_i)
    );

    typedef struct {
        logic [1:0]  req;
        logic        ack;
        logic [31:0] dati;
        logic        cyc;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  gnt;
        logic [1:0]  rack;
        logic        err;
        logic [31:0] rdata;
        logic        busy;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'b01, 1'b0, 32'h0,        1'b1, A0, 32'h0,        4'hF, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0,        1'b1};
        tbl[1]  = '{2'b01, 1'b0, 32'h0,        1'b1, A0, 32'h0,        4'hF, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0,        1'b1};
        tbl[2]  = '{2'b01, 1'b0, 32'h0,        1'b1, A0, 32'h0,        4'hF, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0,        1'b1};
        tbl[3]  = '{2'b01, 1'b1, 32'hDEADBEEF, 1'b0, A0, 32'h0,        4'hF, 1'b0, 2'b01, 2'b01, 1'b0, 32'hDEADBEEF, 1'b1};
        tbl[4]  = '{2'b00, 1'b0, 32'h0,        1'b0, A0, 32'h0,        4'hF, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{2'b10, 1'b0, 32'h0,        1'b1, A1, 32'h12345678, 4'h3, 1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b1};
        tbl[6]  = '{2'b10, 1'b0, 32'h0,        1'b1, A1, 32'h12345678, 4'h3, 1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b1};
        tbl[7]  = '{2'b10, 1'b1, 32'h0,        1'b0, A1, 32'h12345678, 4'h3, 1'b1, 2'b10, 2'b10, 1'b0, 32'h0,        1'b1};
        tbl[8]  = '{2'b00, 1'b0, 32'h0,        1'b0, A1, 32'h0,        4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        tbl[9]  = '{2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, A1, 32'h0,        4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{2'b00, 1'b0, 32'h0,        1'b0, A1, 32'h0,        4'h0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0};

        rst     = 1'b1;
        req     = 2'b00;
        req_we  = 2'b10;
        req_adr = {A1, A0};
        req_dat = {32'h12345678, 32'h0};
        req_sel = {4'h3, 4'hF};
        ack_i   = 1'b0;
        dat_i   = 32'h0;
        tick();
        tick();
        chk("rst_cyc",   {31'b0, cyc_o}, 32'h0);
        chk("rst_stb",   {31'b0, stb_o}, 32'h0);
        chk("rst_gnt",   {30'b0, gnt},   32'h0);
        chk("rst_ack",   {30'b0, rack},  32'h0);
        chk("rst_busy",  {31'b0, busy},  32'h0);
        chk("rst_adr",   adr_o,          32'h0);
        chk("rst_rdata", rdata,          32'h0);
        rst = 1'b0;

        // Single read, wait states, write, stray ACK in IDLE
        for (int i = 0; i < 11; i++) begin
            req   = tbl[i].req;
            ack_i = tbl[i].ack;
            dat_i = tbl[i].dati;
            tick();
            chk($sformatf("v%0d_cyc", i), {31'b0, cyc_o}, {31'b0, tbl[i].cyc});
            chk($sformatf("v%0d_stb", i), {31'b0, stb_o}, {31'b0, tbl[i].cyc});
            chk($sformatf("v%0d_gnt", i), {30'b0, gnt}, {30'b0, tbl[i].gnt});
            chk($sformatf("v%0d_ack", i), {30'b0, rack}, {30'b0, tbl[i].rack});
            chk($sformatf("v%0d_err", i), {31'b0, rerr}, {31'b0, tbl[i].err});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
            if (tbl[i].cyc) begin
                chk($sformatf("v%0d_adr", i), adr_o, tbl[i].adr);
                chk($sformatf("v%0d_dat", i), dat_o, tbl[i].dat);
                chk($sformatf("v%0d_sel", i), {28'b0, sel_o}, {28'b0, tbl[i].sel});
                chk($sformatf("v%0d_we", i), {31'b0, we_o}, {31'b0, tbl[i].we});
            end
            if (tbl[i].rack != 2'b00)
                chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rdata);
        end

        // Contention with a zero-wait slave: grants alternate 0,1,0,1
        req_we = 2'b00;
        req    = 2'b11;
        ack_i  = 1'b1;
        dat_i  = 32'h5555_AAAA;
        for (int k = 0; k < 12; k++) begin
            int ph;
            int g;
            logic [1:0] oh;
            ph = k % 3;
            g  = (k / 3) % 2;
            oh = (g == 0) ? 2'b01 : 2'b10;
            tick();
            if (ph == 0) begin
                chk($sformatf("ct%0d_cyc", k), {31'b0, cyc_o}, 32'h1);
                chk($sformatf("ct%0d_gnt", k), {30'b0, gnt}, {30'b0, oh});
                chk($sformatf("ct%0d_adr", k), adr_o, (g == 0) ? A0 : A1);
                chk($sformatf("ct%0d_ack", k), {30'b0, rack}, 32'h0);
            end else if (ph == 1) begin
                chk($sformatf("ct%0d_cyc", k), {31'b0, cyc_o}, 32'h0);
                chk($sformatf("ct%0d_ack", k), {30'b0, rack}, {30'b0, oh});
                chk($sformatf("ct%0d_rd", k), rdata, 32'h5555_AAAA);
            end else begin
                chk($sformatf("ct%0d_gnt", k), {30'b0, gnt}, 32'h0);
                chk($sformatf("ct%0d_ack", k), {30'b0, rack}, 32'h0);
                chk($sformatf("ct%0d_busy", k), {31'b0, busy}, 32'h0);
            end
        end
        req   = 2'b00;
        ack_i = 1'b0;
        tick();

        // Timeout: slave never acknowledges
        req   = 2'b01;
        dat_i = 32'hBAD0_BAD0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to%0d_cyc", k), {31'b0, cyc_o}, 32'h1);
            chk($sformatf("to%0d_ack", k), {30'b0, rack}, 32'h0);
        end
        tick();
        chk("to_cyc",   {31'b0, cyc_o}, 32'h0);
        chk("to_ack",   {30'b0, rack},  32'h1);
        chk("to_err",   {31'b0, rerr},  32'h1);
        chk("to_rdata", rdata,          32'h0);
        req = 2'b00;
        tick();
        chk("to_idle", {31'b0, busy}, 32'h0);
        req   = 2'b01;
        ack_i = 1'b1;
        dat_i = 32'hCAFE_F00D;
        tick();
        chk("post_cyc", {31'b0, cyc_o}, 32'h1);
        tick();
        chk("post_ack",   {30'b0, rack}, 32'h1);
        chk("post_err",   {31'b0, rerr}, 32'h0);
        chk("post_rdata", rdata,         32'hCAFE_F00D);
        req   = 2'b00;
        ack_i = 1'b0;
        tick();

        // Reset in the second BUS cycle; pointer returns to 0
        req = 2'b11;
        tick();
        chk("pre_rst_gnt", {30'b0, gnt}, 32'h2);
        tick();
        chk("pre_rst_cyc", {31'b0, cyc_o}, 32'h1);
        rst = 1'b1;
        tick();
        chk("mrst_cyc",  {31'b0, cyc_o}, 32'h0);
        chk("mrst_gnt",  {30'b0, gnt},   32'h0);
        chk("mrst_ack",  {30'b0, rack},  32'h0);
        chk("mrst_busy", {31'b0, busy},  32'h0);
        rst = 1'b0;
        tick();
        chk("arst_gnt", {30'b0, gnt}, 32'h1);
        chk("arst_adr", adr_o,        A0);
        chk("arst_ack", {30'b0, rack}, 32'h0);
        ack_i = 1'b1;
        dat_i = 32'h0BAD_CAFE;
        tick();
        chk("arst_rack", {30'b0, rack}, 32'h1);
        req   = 2'b00;
        ack_i = 1'b0;
        tick();
        chk("end_busy", {31'b0, busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
